// File: rtl/stim_loader.sv
// rtl/stim_loader.sv - host byte-stream parser that assembles stimulus and DI command records into their write FIFOs.
module stim_loader #(
   parameter int STF_WIDTH   = 24,
   parameter int CYCLE_RANGE = 5,
   parameter int DIF_WIDTH   = 32
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [7:0]                         in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [STF_WIDTH+CYCLE_RANGE:0]     sfifo_data,
   output logic                               sfifo_wrreq,
   input  logic                               sfifo_wrfull,
   output logic [DIF_WIDTH-1:0]               dififo_data,
   output logic                               dififo_wrreq,
   input  logic                               dififo_wrfull,
   output logic [15:0]                        stim_count,
   output logic [15:0]                        cmd_count,
   output logic [7:0]                         err_count,
   output logic                               done
);

   typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_WRITE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] asm_q, asm_d;
   logic        is_cmd_q, is_cmd_d;
   logic [15:0] stim_count_q, stim_count_d;
   logic [15:0] cmd_count_q, cmd_count_d;
   logic [7:0]  err_count_q, err_count_d;
   logic        done_q, done_d;
   logic        accept;

   // Strobes are gated by reset because reset is synchronous and state may still read WRITE.
   assign in_ready     = ~reset & (state_q != ST_WRITE);
   assign sfifo_wrreq  = ~reset & (state_q == ST_WRITE) & ~is_cmd_q & ~sfifo_wrfull;
   assign dififo_wrreq = ~reset & (state_q == ST_WRITE) & is_cmd_q & ~dififo_wrfull;
   assign sfifo_data   = asm_q[STF_WIDTH+CYCLE_RANGE:0];
   assign dififo_data  = asm_q[DIF_WIDTH-1:0];
   assign stim_count   = stim_count_q;
   assign cmd_count    = cmd_count_q;
   assign err_count    = err_count_q;
   assign done         = done_q;
   assign accept       = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
      is_cmd_d     = is_cmd_q;
      stim_count_d = stim_count_q;
      cmd_count_d  = cmd_count_q;
      err_count_d  = err_count_q;
      done_d       = 1'b0;
      case (state_q)
         ST_HDR: begin
            if (accept) begin
               case (in_data[7:6])
                  2'b01: begin
                     is_cmd_d   = 1'b0;
                     byte_cnt_d = 2'd0;
                     state_d    = ST_PAYLOAD;
                  end
                  2'b10: begin
                     is_cmd_d   = 1'b1;
                     byte_cnt_d = 2'd0;
                     state_d    = ST_PAYLOAD;
                  end
                  2'b11: begin
                     if (in_data[5:0] == 6'h3F) begin
                        done_d = 1'b1;
                     end else if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_PAYLOAD: begin
            if (accept) begin
               asm_d      = {asm_q[23:0], in_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (sfifo_wrreq) begin
               state_d = ST_HDR;
               if (stim_count_q != 16'hFFFF) stim_count_d = stim_count_q + 16'd1;
            end else if (dififo_wrreq) begin
               state_d = ST_HDR;
               if (cmd_count_q != 16'hFFFF) cmd_count_d = cmd_count_q + 16'd1;
            end
         end
         default: state_d = ST_HDR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_HDR;
         byte_cnt_q   <= 2'd0;
         asm_q        <= 32'd0;
         is_cmd_q     <= 1'b0;
         stim_count_q <= 16'd0;
         cmd_count_q  <= 16'd0;
         err_count_q  <= 8'd0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         is_cmd_q     <= is_cmd_d;
         stim_count_q <= stim_count_d;
         cmd_count_q  <= cmd_count_d;
         err_count_q  <= err_count_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: doc/stim_loader.md
STIM_LOADER -- requirements
Module: stim_loader

Interface
REQ-001 Parameter STF_WIDTH, default 24: stimulus test-vector width.
REQ-002 Parameter CYCLE_RANGE, default 5: cycle-count field width.
REQ-003 Parameter DIF_WIDTH, default 32: DI_FIFO entry width ({req[2:0], cmd[4:0], data[23:0]}).
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_data, input, 8: host byte stream.
REQ-007 Port in_valid, input, 1: in_data valid.
REQ-008 Port in_ready, output, 1: loader accepts a byte this cycle.
REQ-009 Port sfifo_data, output, STF_WIDTH+CYCLE_RANGE+1: STIM_FIFO write word {vector, cycles, mode}.
REQ-010 Port sfifo_wrreq, output, 1: STIM_FIFO write strobe.
REQ-011 Port sfifo_wrfull, input, 1: STIM_FIFO full.
REQ-012 Port dififo_data, output, DIF_WIDTH: DI_FIFO write word.
REQ-013 Port dififo_wrreq, output, 1: DI_FIFO write strobe.
REQ-014 Port dififo_wrfull, input, 1: DI_FIFO full.
REQ-015 Port stim_count, output, 16: stimulus records written.
REQ-016 Port cmd_count, output, 16: DI commands written.
REQ-017 Port err_count, output, 8: invalid headers seen.
REQ-018 Port done, output, 1: one-cycle pulse on END record.

Function
REQ-019 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-020 in_ready SHALL be 1 in states HDR and PAYLOAD, 0 in WRITE.
REQ-021 Header byte decode on in_data[7:6]: 00 NOP, 01 STIM, 10 CMD, 11 with in_data[5:0]=6'h3F END, any other 11 header ERR.
REQ-022 HDR: NOP stays HDR; STIM/CMD latches record type, clears byte counter, goes to PAYLOAD; END pulses done next cycle, stays HDR; ERR increments err_count, stays HDR.
REQ-023 PAYLOAD: exactly 4 bytes accepted, MSB first, shifted into a 32-bit assembly register; on 4th accepted byte go to WRITE.
REQ-024 STIM record: sfifo_data SHALL equal assembly[STF_WIDTH+CYCLE_RANGE:0] (bits [29:0] at default); upper bits ignored.
REQ-025 CMD record: dififo_data SHALL equal assembly[DIF_WIDTH-1:0].
REQ-026 WRITE: wrreq of the selected FIFO SHALL be combinational = (state==WRITE) & ~wrfull of that FIFO; the other FIFO's wrreq stays 0.
REQ-027 WRITE exits to HDR in the cycle its wrreq is 1; while wrfull=1 it stays in WRITE with data held stable and in_ready=0.
REQ-028 Latency: 4th payload byte accepted in cycle N -> wrreq=1 in cycle N+1 when not full.
REQ-029 Exactly one FIFO write per STIM/CMD record; never two writes from one record, never a write from NOP/END/ERR.
REQ-030 Record order into each FIFO SHALL match stream order.
REQ-031 stim_count/cmd_count SHALL increment by 1 in each cycle their wrreq is 1; all counters saturate (16'hFFFF, 8'hFF), no wrap.
REQ-032 in_valid=0 mid-PAYLOAD SHALL hold state and partial data indefinitely.
REQ-033 sfifo_data/dififo_data SHALL be don't-care outside WRITE; wrreq SHALL never assert outside WRITE.

Reset
REQ-034 reset=1 at a rising edge: state HDR, byte counter 0, assembly 0, stim_count/cmd_count/err_count 0, done 0.
REQ-035 While reset=1: in_ready, sfifo_wrreq, dififo_wrreq all 0.
REQ-036 Reset mid-PAYLOAD or mid-WRITE SHALL discard the partial record with no FIFO write; first byte after reset is a header.

Verification
REQ-037 Stream 40 12 34 56 7F, FIFOs not full -> one cycle sfifo_wrreq=1, sfifo_data=30'h1234567F, stim_count=1.
REQ-038 Stream 80 01 AA BB CC -> dififo_wrreq=1 once, dififo_data=32'h01AABBCC, cmd_count=1, sfifo_wrreq never 1.
REQ-039 STIM record with sfifo_wrfull=1 for 5 cycles after 4th byte -> in_ready=0, no write for 5 cycles, single write in cycle 6, data unchanged.
REQ-040 Stream C1 00 FF -> err_count=1 after C1, state HDR; then FF -> done pulse exactly one cycle, no FIFO writes.
REQ-041 Stream 40 11 22 then reset 1 cycle, then 40 AA BB CC DD -> single write sfifo_data=30'h2ABBCCDD, stim_count=1.
REQ-042 Stream 256 ERR headers (C0) -> err_count saturates at 8'hFF.
